// File: rtl/mod_n_down_if.sv
// Control/status bundle for the mod-N down counter: the master drives
// en/load/load_val, and the counter (slave) returns out/tc/wraps/done.
interface mod_n_down_if #(
    parameter int unsigned N = 17,
    parameter int unsigned W = $clog2(N)
);
    logic         en;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] out;
    logic         tc;
    logic [7:0]   wraps;
    logic         done;

    modport master (
        output en, load, load_val,
        input  out, tc, wraps, done
    );

    modport slave (
        input  en, load, load_val,
        output out, tc, wraps, done
    );
endinterface

// File: rtl/mod_n_down.sv
// Modulo-N down counter (N-1 .. 0, wrap) with load clamp, tc pulse and wrap count.
// Define MOD_N_DOWN_ONESHOT_EN to stop at 0 and raise done instead of wrapping.
module mod_n_down #(
    parameter int unsigned N = 17,
    parameter int unsigned W = $clog2(N)
) (
    input  logic        clk,
    input  logic        rst,
    mod_n_down_if.slave bus
);
    localparam logic [W-1:0] MAX = W'(N - 1);

    logic [W-1:0] cnt_q, cnt_d;
    logic         tc_q, tc_d;
    logic [7:0]   wraps_q, wraps_d;
    logic [W-1:0] load_cnt;

    // Out-of-range loads clamp to the top of the count range.
    assign load_cnt = (bus.load_val > MAX) ? MAX : bus.load_val;

`ifdef MOD_N_DOWN_ONESHOT_EN
    typedef enum logic {
        ST_COUNT,
        ST_HALT
    } state_t;

    state_t state_q, state_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_COUNT;
        end else begin
            state_q <= state_d;
        end
    end

    assign bus.done = (state_q == ST_HALT);
`else
    assign bus.done = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= MAX;
            tc_q    <= 1'b0;
            wraps_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            tc_q    <= tc_d;
            wraps_q <= wraps_d;
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        tc_d    = 1'b0;
        wraps_d = wraps_q;
`ifdef MOD_N_DOWN_ONESHOT_EN
        state_d = state_q;
`endif
        if (bus.load) begin
            cnt_d = load_cnt;
`ifdef MOD_N_DOWN_ONESHOT_EN
            state_d = ST_COUNT;
`endif
        end else if (bus.en) begin
`ifdef MOD_N_DOWN_ONESHOT_EN
            // Halted: count sits at 0 until a load or reset.
            if (state_q == ST_COUNT) begin
                if (cnt_q == '0) begin
                    tc_d    = 1'b1;
                    wraps_d = wraps_q + 8'd1;
                    state_d = ST_HALT;
                end else begin
                    cnt_d = cnt_q - W'(1);
                end
            end
`else
            if (cnt_q == '0) begin
                cnt_d   = MAX;
                tc_d    = 1'b1;
                wraps_d = wraps_q + 8'd1;
            end else begin
                cnt_d = cnt_q - W'(1);
            end
`endif
        end
    end

    assign bus.out   = cnt_q;
    assign bus.tc    = tc_q;
    assign bus.wraps = wraps_q;

    a_out_in_range : assert property (@(posedge clk) cnt_q <= MAX);
    a_tc_single    : assert property (@(posedge clk) disable iff (rst) tc_q |=> !tc_q);
endmodule
